mem_arbiter: RTL

//  Single-port arbiter between the I-cache and D-cache miss/write paths and the

---
 rtl/mem_arbiter_if.sv | 64 ++++++
 rtl/mem_arbiter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
//   Bundles every handshake and bus signal between the two cache clients,
//   the arbiter and the shared pipelined main memory.
//   Modports:
//     slave  - the arbiter (mem_arbiter) side
//     master - the client / memory side (caches, memory, testbench)
//   Signal groups:
//     I-cache : i_req, i_addr -> i_grant, i_data, i_valid, i_word, i_done
//     D-cache : d_req, d_wr, d_addr, d_wdata -> d_grant, d_data, d_valid,
//               d_word, d_done
//     memory  : mem_en, mem_wr, mem_addr, mem_wdata <- mem_rdata, mem_valid
// ---------------------------------------------------------------------------
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned WORD_W = 3
);
    // I-cache fill path
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_grant;
    logic [DATA_W-1:0] i_data;
    logic              i_valid;
    logic [WORD_W-1:0] i_word;
    logic              i_done;

    // D-cache fill / store path
    logic              d_req;
    logic              d_wr;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_grant;
    logic [DATA_W-1:0] d_data;
    logic              d_valid;
    logic [WORD_W-1:0] d_word;
    logic              d_done;

    // Shared main memory
    logic              mem_en;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_valid;

    modport slave (
        input  i_req, i_addr,
        output i_grant, i_data, i_valid, i_word, i_done,
        input  d_req, d_wr, d_addr, d_wdata,
        output d_grant, d_data, d_valid, d_word, d_done,
        output mem_en, mem_wr, mem_addr, mem_wdata,
        input  mem_rdata, mem_valid
    );

    modport master (
        output i_req, i_addr,
        input  i_grant, i_data, i_valid, i_word, i_done,
        output d_req, d_wr, d_addr, d_wdata,
        input  d_grant, d_data, d_valid, d_word, d_done,
        input  mem_en, mem_wr, mem_addr, mem_wdata,
        output mem_rdata, mem_valid
    );
endinterface

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Single-port arbiter between the I-cache / D-cache miss and write paths and
//   a shared, fixed-latency, in-order pipelined main memory. Owns the block
//   fill burst (WORDS_PER_BLK word reads from the aligned block base, words
//   returned with index and a done pulse) and forwards single-word D-cache
//   write-through stores. D-cache has fixed priority at transaction boundaries.
//   Ports:
//     clk    - rising-edge clock
//     rst_n  - synchronous active-low reset
//     bus    - mem_arbiter_if.slave (cache handshakes + memory bus)
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int unsigned MEM_LAT       = 4,
    parameter int unsigned WORDS_PER_BLK = 8,
    parameter int unsigned ADDR_W        = 16,
    parameter int unsigned DATA_W        = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);
    localparam int unsigned      WORD_W    = $clog2(WORDS_PER_BLK);
    localparam logic [ADDR_W-1:0] BLK_MASK = ADDR_W'(2 * WORDS_PER_BLK - 1);
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WORDS_PER_BLK - 1);

    typedef enum logic [1:0] {
        IDLE,
        I_FILL,
        D_FILL,
        D_STORE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] base_next;
    // Extra MSB marks "all reads issued" (WORDS_PER_BLK is a power of 2).
    logic [WORD_W:0]   issue_cnt;
    logic [WORD_W-1:0] ret_cnt;
    // One bit per outstanding read slot; the MSB marks the cycle in which a
    // read issued by this burst is due back. Cleared by reset, so returns of
    // reads issued before a reset are never matched.
    logic [MEM_LAT-1:0] rd_pipe;

    logic fill;
    logic issuing;
    logic ret_ok;
    logic ret_last;
    logic i_ret;
    logic d_ret;
    logic arb;
    logic allow_i;
    logic allow_d;

    // -----------------------------------------------------------------------
    // Burst progress decode
    // -----------------------------------------------------------------------
    always_comb begin
        fill     = (state == I_FILL) || (state == D_FILL);
        issuing  = fill && !issue_cnt[WORD_W];
        ret_ok   = fill && bus.mem_valid && rd_pipe[MEM_LAT-1];
        ret_last = ret_ok && (ret_cnt == LAST_WORD);
        i_ret    = ret_ok && (state == I_FILL);
        d_ret    = ret_ok && (state == D_FILL);
    end

    // -----------------------------------------------------------------------
    // Next-state / arbitration
    // A finishing transaction hands over directly to a waiting request so its
    // grant rises the cycle after done; the finishing port's own request is
    // still high during its done cycle and is excluded from that handover.
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state;
        base_next  = base;
        arb        = 1'b0;
        allow_i    = 1'b1;
        allow_d    = 1'b1;

        unique case (state)
            IDLE: begin
                arb = 1'b1;
            end
            I_FILL: begin
                if (ret_last) begin
                    arb     = 1'b1;
                    allow_i = 1'b0;
                end
            end
            D_FILL: begin
                if (ret_last) begin
                    arb     = 1'b1;
                    allow_d = 1'b0;
                end
            end
            D_STORE: begin
                arb     = 1'b1;
                allow_d = 1'b0;
            end
            default: begin
                arb = 1'b1;
            end
        endcase

        if (arb) begin
            if (bus.d_req && allow_d) begin
                state_next = bus.d_wr ? D_STORE : D_FILL;
                base_next  = bus.d_addr & ~BLK_MASK;
            end else if (bus.i_req && allow_i) begin
                state_next = I_FILL;
                base_next  = bus.i_addr & ~BLK_MASK;
            end else begin
                state_next = IDLE;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    always_comb begin
        bus.i_grant   = (state == I_FILL);
        bus.d_grant   = (state == D_FILL) || (state == D_STORE);

        bus.mem_en    = issuing || (state == D_STORE);
        bus.mem_wr    = (state == D_STORE);
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (issuing) begin
            bus.mem_addr = base + ADDR_W'({issue_cnt[WORD_W-1:0], 1'b0});
        end else if (state == D_STORE) begin
            bus.mem_addr  = bus.d_addr;
            bus.mem_wdata = bus.d_wdata;
        end

        bus.i_valid = i_ret;
        bus.i_done  = i_ret && ret_last;
        bus.i_data  = i_ret ? bus.mem_rdata : '0;
        bus.i_word  = i_ret ? ret_cnt : '0;

        bus.d_valid = d_ret;
        bus.d_done  = (d_ret && ret_last) || (state == D_STORE);
        bus.d_data  = d_ret ? bus.mem_rdata : '0;
        bus.d_word  = d_ret ? ret_cnt : '0;
    end

    // -----------------------------------------------------------------------
    // State, base and counters
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            base      <= '0;
            issue_cnt <= '0;
            ret_cnt   <= '0;
            rd_pipe   <= '0;
        end else begin
            state   <= state_next;
            base    <= base_next;
            rd_pipe <= (rd_pipe << 1) | MEM_LAT'(issuing);
            // Every transaction exits through a state change, so counters
            // restart on any transition.
            if (state_next != state) begin
                issue_cnt <= '0;
                ret_cnt   <= '0;
            end else begin
                if (issuing) begin
                    issue_cnt <= issue_cnt + (WORD_W + 1)'(1);
                end
                if (ret_ok) begin
                    ret_cnt <= ret_cnt + WORD_W'(1);
                end
            end
        end
    end
endmodule
